mag_cmp_serial: RTL and testbench



---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_chunk.sv | 18 +
 rtl/mag_cmp_serial.sv | 122 ++++++++++++
 tb/tb_mag_cmp_serial.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the serial magnitude comparator.
// Consumers decode {equal, gt, lt} with the RES_* localparams below.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot result word, ordered {equal, gt, lt}; RES_NONE while busy or after reset.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    // Chunk index width; a single-chunk compare still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Purpose: CHUNK-bit unsigned combinational magnitude comparator.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module cmp_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_serial.sv
// Purpose: MSB-first serial magnitude compare, CHUNK bits per cycle, signed or unsigned.
// Latency: 1 cycle (first chunk differs) up to WIDTH/CHUNK cycles (equal operands).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module mag_cmp_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             gt,
    output logic             lt
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    // Flipping the sign bit of both operands turns two's-complement order into unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % CHUNK) != 0 || NUM_CHUNKS < 1) begin : g_bad_params
        $error("mag_cmp_serial: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sa_n;
    logic [WIDTH-1:0] sb, sb_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [2:0]       res, res_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    logic c_eq, c_gt, c_lt;

    cmp_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a  (sa[WIDTH-1 -: CHUNK]),
        .b  (sb[WIDTH-1 -: CHUNK]),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            idx    <= '0;
            res    <= RES_NONE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            sa     <= sa_n;
            sb     <= sb_n;
            idx    <= idx_n;
            res    <= res_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        idx_n   = idx;
        res_n   = res;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    sa_n    = a ^ (signed_mode ? MSB_MASK : '0);
                    sb_n    = b ^ (signed_mode ? MSB_MASK : '0);
                    idx_n   = '0;
                    res_n   = RES_NONE;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!c_eq) begin
                    res_n   = c_gt ? RES_GT : RES_LT;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (idx == LAST_IDX) begin
                    res_n   = RES_EQ;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    sa_n  = sa << CHUNK;
                    sb_n  = sb << CHUNK;
                    idx_n = idx + IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN);
    end

    // c_lt is implied by !c_eq && !c_gt; it is kept on the instance for readability.
    logic unused_lt;
    assign unused_lt = c_lt;

    assign busy  = busy_q;
    assign done  = done_q;
    assign equal = res[2];
    assign gt    = res[1];
    assign lt    = res[0];

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Directed and random checks of mag_cmp_serial (WIDTH=16, CHUNK=4): flags, done latency,
// busy/back-to-back handshake and synchronous reset abort.
module tb_mag_cmp_serial;

    localparam logic [2:0] E_NONE = 3'b000;
    localparam logic [2:0] E_EQ   = 3'b100;
    localparam logic [2:0] E_GT   = 3'b010;
    localparam logic [2:0] E_LT   = 3'b001;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic        equal;
    logic        gt;
    logic        lt;

    int n_tests = 0;
    int n_fail  = 0;

    mag_cmp_serial #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .gt          (gt),
        .lt          (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected flags from a direct signed/unsigned compare; latency from the topmost differing chunk.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msm,
                         output logic [2:0] res, output int lat);
        logic [15:0] x;
        x   = ma ^ mb;
        lat = 4;
        for (int k = 0; k < 4; k++)
            if (x[4*k +: 4] != 4'h0) lat = 4 - k;
        if (ma == mb)
            res = E_EQ;
        else if (msm ? ($signed(ma) > $signed(mb)) : (ma > mb))
            res = E_GT;
        else
            res = E_LT;
    endtask

    // Called just after a rising edge; issues start and follows the compare to its done cycle.
    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tsm, input logic [2:0] exp_res, input int exp_lat,
                       input bit hold);
        int lat;
        a           = ta;
        b           = tb_v;
        signed_mode = tsm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_clr"},   32'({equal, gt, lt}), 32'(E_NONE));
        check({tag, "_done0"}, 32'(done), 32'd0);
        if (hold) begin
            a           = ~ta;
            b           = ta;
            signed_mode = ~tsm;
        end else begin
            start = 1'b0;
        end
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_lat"},  32'(lat), 32'(exp_lat));
        check({tag, "_res"},  32'({equal, gt, lt}), 32'(exp_res));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, mask;
        logic        rsm;
        logic [2:0]  eres;
        int          elat;
        bit          seen;

        rst         = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res",  32'({equal, gt, lt}), 32'(E_NONE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("eq_1234",   16'h1234, 16'h1234, 1'b0, E_EQ, 4, 1'b0);
        run("u_8000",    16'h8000, 16'h7FFF, 1'b0, E_GT, 1, 1'b0);
        run("s_8000",    16'h8000, 16'h7FFF, 1'b1, E_LT, 1, 1'b0);
        run("s_ffff",    16'hFFFF, 16'h0000, 1'b1, E_LT, 1, 1'b0);
        run("u_ffff",    16'hFFFF, 16'h0000, 1'b0, E_GT, 1, 1'b0);
        run("gt_1300",   16'h1300, 16'h12FF, 1'b0, E_GT, 2, 1'b0);
        run("lt_12f4",   16'h12F4, 16'h12F5, 1'b0, E_LT, 4, 1'b0);
        run("hold_busy", 16'h5555, 16'h5555, 1'b0, E_EQ, 4, 1'b1);
        // Issued in the done cycle of the previous compare.
        run("b2b_0001",  16'h0001, 16'h0002, 1'b0, E_LT, 4, 1'b0);

        // Reset during the second RUN cycle of an equal-operand compare.
        a     = 16'h1234;
        b     = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy1", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res",  32'({equal, gt, lt}), 32'(E_NONE));
        seen = done;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_nodone", 32'(seen), 32'd0);
        check("abort_res2",   32'({equal, gt, lt}), 32'(E_NONE));
        run("post_rst", 16'hA000, 16'hA001, 1'b1, E_LT, 4, 1'b0);

        // Back-to-back random compares; b shares a random number of leading chunks with a.
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsm  = 1'($urandom_range(0, 1));
            mask = ~(16'hFFFF >> (4 * $urandom_range(0, 4)));
            rb   = (ra & mask) | (rb & ~mask);
            model(ra, rb, rsm, eres, elat);
            run($sformatf("rnd%0d", i), ra, rb, rsm, eres, elat, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
